// File: rtl/pipe_reg_skid.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// in_ready is decoded from state only, so the ready path is registered in both directions.
module pipe_reg_skid #(
    parameter int unsigned        DATA_W       = 32,
    parameter logic [DATA_W-1:0]  RST_VAL      = '0,
    parameter bit                 CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              m_q, m_d;
    logic              s_q, s_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              consume;

    assign in_ready  = ~s_q;
    assign out_valid = m_q;
    assign out_data  = main_q;
    assign count     = {1'b0, m_q} + {1'b0, s_q};

    assign accept  = in_valid & ~s_q & ~flush;
    assign consume = m_q & out_ready & ~flush;

    always_comb begin
        m_d    = m_q;
        s_d    = s_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            m_d = 1'b0;
            s_d = 1'b0;
            if (CLR_ON_FLUSH) begin
                main_d = RST_VAL;
                skid_d = RST_VAL;
            end
        end else begin
            case ({m_q, s_q})
                2'b00: begin
                    if (accept) begin
                        main_d = in_data;
                        m_d    = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (consume) begin
                        m_d = 1'b0;
                    end else if (accept) begin
                        skid_d = in_data;
                        s_d    = 1'b1;
                    end
                end
                2'b11: begin
                    if (consume) begin
                        main_d = skid_q;
                        s_d    = 1'b0;
                    end
                end
                default: begin
                    // Unreachable; fall back to empty rather than hold a skid-only entry.
                    m_d = 1'b0;
                    s_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= 1'b0;
            s_q    <= 1'b0;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            m_q    <= m_d;
            s_q    <= s_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed steps then random stress against a queue model,
// driving four instances (32b clear, 32b no-clear, 8b, 64b) with shared stimulus.
module tb_pipe_reg_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c, rdy_d, vld_d;
    logic [31:0] dat_a, dat_b;
    logic [7:0]  dat_c;
    logic [63:0] dat_d;
    logic [1:0]  cnt_a, cnt_b, cnt_c, cnt_d;

    int total = 0;
    int bad   = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    pipe_reg_skid #(.DATA_W(32), .RST_VAL(32'h0), .CLR_ON_FLUSH(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data[31:0]), .out_valid(vld_a), .out_ready(out_ready),
        .out_data(dat_a), .count(cnt_a)
    );
    pipe_reg_skid #(.DATA_W(32), .RST_VAL(32'h0), .CLR_ON_FLUSH(1'b0)) u_nc (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data[31:0]), .out_valid(vld_b), .out_ready(out_ready),
        .out_data(dat_b), .count(cnt_b)
    );
    pipe_reg_skid #(.DATA_W(8), .RST_VAL(8'h0), .CLR_ON_FLUSH(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data[7:0]), .out_valid(vld_c), .out_ready(out_ready),
        .out_data(dat_c), .count(cnt_c)
    );
    pipe_reg_skid #(.DATA_W(64), .RST_VAL(64'h0), .CLR_ON_FLUSH(1'b1)) u_w64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(in_data), .out_valid(vld_d), .out_ready(out_ready),
        .out_data(dat_d), .count(cnt_d)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input int w, input logic vld, input logic rdy,
                           input logic [1:0] cnt, input logic [63:0] dat,
                           input logic m, input logic s);
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        chk({tag, ".out_valid"}, {63'd0, vld}, {63'd0, q.size() > 0});
        chk({tag, ".count"}, {62'd0, cnt}, 64'(q.size()));
        chk({tag, ".in_ready"}, {63'd0, rdy}, {63'd0, q.size() < 2});
        chk({tag, ".in_ready_vs_s"}, {63'd0, rdy}, {63'd0, ~s});
        chk({tag, ".no_skid_only"}, {63'd0, !m && s}, 64'd0);
        if (q.size() > 0) chk({tag, ".out_data"}, dat, q[0] & mask);
    endtask

    task automatic check_all();
        chk_dut("c32", 32, vld_a, rdy_a, cnt_a, {32'd0, dat_a}, u_dut.m_q, u_dut.s_q);
        chk_dut("n32", 32, vld_b, rdy_b, cnt_b, {32'd0, dat_b}, u_nc.m_q, u_nc.s_q);
        chk_dut("w8", 8, vld_c, rdy_c, cnt_c, {56'd0, dat_c}, u_w8.m_q, u_w8.s_q);
        chk_dut("w64", 64, vld_d, rdy_d, cnt_d, dat_d, u_w64.m_q, u_w64.s_q);
    endtask

    // One clock: update the FIFO model from the inputs seen at the edge, then check.
    task automatic cycle();
        logic acc, con;
        @(posedge clk);
        acc = in_valid && (q.size() < 2) && !flush;
        con = (q.size() > 0) && out_ready && !flush;
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(in_data);
        end
        #1;
        check_all();
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, ".out_valid"}, {60'd0, vld_a, vld_b, vld_c, vld_d}, 64'd0);
        chk({tag, ".count"}, {56'd0, cnt_a, cnt_b, cnt_c, cnt_d}, 64'd0);
        chk({tag, ".in_ready"}, {60'd0, rdy_a, rdy_b, rdy_c, rdy_d}, 64'hF);
        chk({tag, ".out_data32"}, {dat_a, dat_b}, 64'd0);
        chk({tag, ".out_data8_64"}, dat_d | {56'd0, dat_c}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset is visible before any clock edge
        #3;
        reset_outputs_zero("reset_async");
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        chk("post_reset_data", {32'd0, dat_a}, 64'd0);

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h11 + 64'(i);
            cycle();
            chk("stream_data", {32'd0, dat_a}, 64'h11 + 64'(i));
            chk("stream_count", {62'd0, cnt_a}, 64'd1);
            chk("stream_ready", {63'd0, rdy_a}, 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure fill and drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA1;
        cycle();
        in_data = 64'hA2;
        cycle();
        chk("bp_full_count", {62'd0, cnt_a}, 64'd2);
        chk("bp_full_ready", {63'd0, rdy_a}, 64'd0);
        in_data = 64'hA3;
        cycle();
        cycle();
        chk("bp_stable_data", {32'd0, dat_a}, 64'hA1);
        chk("bp_stable_count", {62'd0, cnt_a}, 64'd2);
        out_ready = 1'b1;
        cycle();
        chk("drain1_data", {32'd0, dat_a}, 64'hA2);
        chk("drain1_ready", {63'd0, rdy_a}, 64'd1);
        cycle();
        chk("drain2_data", {32'd0, dat_a}, 64'hA3);
        in_valid = 1'b0;
        cycle();
        chk("drain3_valid", {63'd0, vld_a}, 64'd0);

        // Flush with a transfer offered in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD1;
        cycle();
        in_data = 64'hD2;
        cycle();
        flush = 1'b1; in_data = 64'hBB;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", {62'd0, cnt_a}, 64'd0);
        chk("flush_valid", {63'd0, vld_a}, 64'd0);
        chk("flush_clr_data", {32'd0, dat_a}, 64'd0);
        chk("flush_noclr_data", {32'd0, dat_b}, 64'hD1);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("flush_no_bb", {63'd0, vld_a}, 64'd0);
        chk("flush_noclr_hold", {32'd0, dat_b}, 64'hD1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE1;
        cycle();
        in_data = 64'hE2;
        cycle();
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        q.delete();
        reset_outputs_zero("reset_mid");
        #1 rst = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hC3;
        cycle();
        chk("post_reset_first", {32'd0, dat_a}, 64'hC3);
        in_valid = 1'b0;
        cycle();

        // Random stress
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) < 5);
            in_data   = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised elastic pipeline register that generalises the plain enable flip-flop into a valid/ready register slice with a 2-entry skid buffer and a synchronous flush. It sits between pipeline stages of the pipelined core, for example IF/ID and ID/EX. Stall is expressed by out_ready low, and branch/exception squash by flush. in_ready is a pure register decode, so no combinational path exists from out_ready to in_ready, and timing between stages is cut in both directions.

Parameters:
DATA_W, 32, payload width in bits; must be 1 or greater.
RST_VAL, 0, value loaded into both data registers on reset (DATA_W bits).
CLR_ON_FLUSH, 1, 1 loads RST_VAL into the data registers on flush; 0 leaves the data registers unchanged on flush.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream offers in_data.
in_ready  output  1  slice can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a valid entry.
out_ready  input  1  downstream consumes this cycle.
out_data  output  DATA_W  payload of the oldest entry.
count  output  2  occupancy, 0 to 2.

Behaviour:
- State: main register (M valid bit, main data) drives out_valid/out_data. Skid register (S valid bit, skid data) holds the overflow entry.
- Outputs: out_valid=M; in_ready=!S; count=M+S. in_ready depends only on state, never on out_ready or in_valid.
- Reset (rst=0, effective immediately, no clock edge needed):
  - M=S=0, so out_valid=0, count=0, in_ready=1.
  - Main data and skid data = RST_VAL.
  - Reset asserted mid-stream discards all entries.
- Transfers: accept = in_valid & in_ready & !flush; consume = out_valid & out_ready & !flush.
- Next state, priority order:
  1. flush=1:
     - M=S=0 next cycle.
     - A transfer offered in the flush cycle is dropped; upstream is squashed by the same flush.
     - Data registers load RST_VAL if CLR_ON_FLUSH=1, otherwise hold.
  2. State EMPTY (M=0,S=0):
     - accept: main data <= in_data, M=1.
     - Latency is 1 cycle from acceptance to out_valid.
  3. State ONE (M=1,S=0):
     - accept & consume: main data <= in_data, M stays 1. Full throughput, 1 item per cycle.
     - consume only: M=0.
     - accept only: skid data <= in_data, S=1; in_ready falls the next cycle.
     - neither: hold.
  4. State FULL (M=1,S=1), where in_ready=0:
     - consume: main data <= skid data, S=0.
     - otherwise hold.
  5. M=0,S=1 is unreachable; the bench asserts it never occurs.
- Ordering: strict FIFO; no entry is lost or duplicated outside flush/reset.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Data registers load only on the events listed above, so there is no toggling on idle cycles.

Test Plan:
1. Reset: drive rst=0 with no clock edge, RST_VAL=0 -> out_valid=0, count=0, in_ready=1, out_data=0 immediately; after rst=1 the state is unchanged until the first accept.
2. Streaming: out_ready=1, push 0x11 to 0x18 on consecutive cycles -> out_data=0x11..0x18 in order, each 1 cycle after acceptance; in_ready stays 1 and count stays 1 throughout.
3. Backpressure:
   - Setup: out_ready=0, offer 0xA1, 0xA2, 0xA3.
   - Fill: 0xA1 and 0xA2 accepted; count=2, in_ready=0; 0xA3 held by upstream; out_data=0xA1 stable.
   - Drain: raise out_ready -> output sequence 0xA1, 0xA2, 0xA3; in_ready returns to 1 one cycle after the first consume.
4. Flush:
   - Setup: count=2, pulse flush while in_valid=1 with 0xBB.
   - Required: next cycle count=0, out_valid=0, out_data=RST_VAL; 0xBB never appears at the output.
   - Repeat with CLR_ON_FLUSH=0: out_data keeps its last value while out_valid=0.
5. Async reset mid-stream: count=2, drop rst between clock edges -> outputs clear within the same cycle; after release, the first push 0xC3 is the first item out.
6. Random stress: DATA_W=8 and DATA_W=64, 2000 cycles of random in_valid/out_ready/flush at 5% -> scoreboard matches in order; count never exceeds 2; M=0 with S=1 never seen; in_ready equals !S every cycle.
